// File: rtl/ecall_service_pkg.sv
// Shared definitions for the ecall responder: service codes, FSM state
// encoding and the service-number decoder.
package ecall_defs;

  localparam logic [31:0] PRINT_INT = 32'd1;
  localparam logic [31:0] READ_INT  = 32'd5;
  localparam logic [31:0] EXIT      = 32'd10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ARM          = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_PULSE        = 3'd4,
    ST_COOLDOWN     = 3'd5,
    ST_HALT         = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SVC_NOP   = 2'd0,
    SVC_PRINT = 2'd1,
    SVC_READ  = 2'd2,
    SVC_EXIT  = 2'd3
  } svc_t;

  function automatic svc_t decode_svc(input logic [31:0] code);
    case (code)
      PRINT_INT: return SVC_PRINT;
      READ_INT:  return SVC_READ;
      EXIT:      return SVC_EXIT;
      default:   return SVC_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ecall_service_debounce.sv
// Button conditioner: two-flop synchroniser followed by a stability counter;
// the clean level only follows the input after DEBOUNCE_CYCLES steady cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_inc == CNT_LAST) begin
      // the D-th consecutive disagreeing sample flips the clean level
      cnt_d   = '0;
      clean_d = sync2_q;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/ecall_service.sv
// Responder side of the ecall/continue handshake: performs the board I/O for
// a service call and releases fetch with a single clean continue pulse.
module ecall_service
  import ecall_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PC_WIDTH        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ecall,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic [15:0]         switches,
  input  logic                button_raw,
  output logic                continue_button,
  output logic                wb_en,
  output logic [31:0]         rd_data,
  output logic [31:0]         display,
  output logic                halted,
  output logic                busy
);

  logic                clean;
  state_t              state_q, state_d;
  svc_t                svc_q, svc_d;
  logic [PC_WIDTH-1:0] ecall_pc_q, ecall_pc_d;
  logic [31:0]         display_q, display_d;
  logic [31:0]         rd_data_q, rd_data_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (button_raw),
    .clean(clean)
  );

  always_comb begin
    state_d    = state_q;
    svc_d      = svc_q;
    ecall_pc_d = ecall_pc_q;
    display_d  = display_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ecall) begin
          ecall_pc_d = pc;
          svc_d      = decode_svc(a7);
          case (decode_svc(a7))
            SVC_EXIT:  state_d = ST_HALT;
            SVC_PRINT: begin
              display_d = a0;
              state_d   = ST_ARM;
            end
            SVC_READ:  state_d = ST_ARM;
            default:   state_d = ST_PULSE;
          endcase
        end
      end
      // a button still held from the previous call must be released first
      ST_ARM: begin
        if (!ecall)      state_d = ST_IDLE;
        else if (!clean) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (!ecall)     state_d = ST_IDLE;
        else if (clean) state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!ecall) begin
          state_d = ST_IDLE;
        end else if (!clean) begin
          state_d = ST_PULSE;
          if (svc_q == SVC_READ) rd_data_d = {16'h0000, switches};
        end
      end
      ST_PULSE: state_d = ST_COOLDOWN;
      // ecall stays high across back-to-back calls, so wait for fetch to move
      ST_COOLDOWN: begin
        if (pc != ecall_pc_q) state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      svc_q      <= SVC_NOP;
      ecall_pc_q <= '0;
      display_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      svc_q      <= svc_d;
      ecall_pc_q <= ecall_pc_d;
      display_q  <= display_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign continue_button = (state_q == ST_PULSE);
  assign wb_en           = (state_q == ST_PULSE) && (svc_q == SVC_READ);
  assign halted          = (state_q == ST_HALT);
  assign busy            = (state_q != ST_IDLE);
  assign display         = display_q;
  assign rd_data         = rd_data_q;

endmodule

// File: tb/tb_ecall_service.sv
// Bench for ecall_service: a transaction-level reference model of the
// handshake plus directed test-plan scenarios and randomized service calls.
module tb_ecall_service;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ecall;
  logic [15:0] pc = 16'h0010;
  logic [31:0] a7, a0;
  logic [15:0] switches;
  logic        button_raw;
  logic        continue_button, wb_en, halted, busy;
  logic [31:0] rd_data, display;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ecall_service #(
    .DEBOUNCE_CYCLES(D),
    .PC_WIDTH       (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ecall          (ecall),
    .pc             (pc),
    .a7             (a7),
    .a0             (a0),
    .switches       (switches),
    .button_raw     (button_raw),
    .continue_button(continue_button),
    .wb_en          (wb_en),
    .rd_data        (rd_data),
    .display        (display),
    .halted         (halted),
    .busy           (busy)
  );

  // Fetch model: one PC advance per falling edge of continue_button, plus an
  // explicit load used by the directed tests.
  logic        prev_cb = 1'b0;
  int          load_seq = 0;
  int          seen_seq = 0;
  logic [15:0] pc_load_val = 16'h0000;

  always @(negedge clock) begin
    if (load_seq != seen_seq) begin
      pc       <= pc_load_val;
      seen_seq <= load_seq;
    end else if (prev_cb && !continue_button) begin
      pc <= pc + 16'd4;
    end
    prev_cb <= continue_button;
  end

  // Reference model: handshake progress counted in clean-level transitions,
  // clean level derived from a history of raw samples.
  bit          rh [0:D+1];
  bit          m_clean, m_halt, m_pulse, m_cool, m_wait, m_read;
  int          m_stage;
  logic [15:0] m_pc;
  logic [31:0] m_disp, m_rd;

  task automatic model_clear();
    for (int i = 0; i <= D + 1; i++) rh[i] = 1'b0;
    m_clean = 0; m_halt = 0; m_pulse = 0; m_cool = 0; m_wait = 0; m_read = 0;
    m_stage = 0; m_pc = '0; m_disp = '0; m_rd = '0;
  endtask

  task automatic model_step();
    bit all_diff;
    if (m_halt) begin
    end else if (m_pulse) begin
      m_pulse = 0;
      m_cool  = 1;
    end else if (m_cool) begin
      if (pc != m_pc) m_cool = 0;
    end else if (m_wait) begin
      if (!ecall) m_wait = 0;
      else if (m_stage == 0 && !m_clean) m_stage = 1;
      else if (m_stage == 1 && m_clean) m_stage = 2;
      else if (m_stage == 2 && !m_clean) begin
        m_wait  = 0;
        m_pulse = 1;
        if (m_read) m_rd = {16'h0000, switches};
      end
    end else if (ecall) begin
      m_pc   = pc;
      m_read = (a7 == 32'd5);
      if (a7 == 32'd10) m_halt = 1;
      else if (a7 == 32'd1 || a7 == 32'd5) begin
        m_wait  = 1;
        m_stage = 0;
        if (a7 == 32'd1) m_disp = a0;
      end else m_pulse = 1;
    end
    for (int i = D + 1; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = button_raw;
    all_diff = 1;
    for (int i = 2; i <= D + 1; i++) if (rh[i] == m_clean) all_diff = 0;
    if (all_diff) m_clean = !m_clean;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check1 ("continue_button", continue_button, m_pulse);
    check1 ("wb_en",           wb_en,           m_pulse & m_read);
    check1 ("halted",          halted,          m_halt);
    check1 ("busy",            busy,            m_halt | m_pulse | m_cool | m_wait);
    check32("display",         display,         m_disp);
    check32("rd_data",         rd_data,         m_rd);
  endtask

  task automatic tick();
    @(negedge clock);
    compare_all();
  endtask

  task automatic press(input int hold);
    button_raw = 1'b1;
    repeat (hold) tick();
    button_raw = 1'b0;
  endtask

  task automatic wait_pulse(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (continue_button) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int np;
    int sel;
    reset = 1'b0; ecall = 1'b0; a7 = '0; a0 = '0; switches = '0; button_raw = 1'b0;
    repeat (2) tick();
    check1 ("rst_continue", continue_button, 1'b0);
    check1 ("rst_busy",     busy,            1'b0);
    check32("rst_display",  display,         32'h0);
    reset = 1'b1;
    tick();

    // NOP service: immediate pulse, busy until fetch moves
    a7 = 32'd0; ecall = 1'b1;
    tick();
    check1("nop_pulse",    continue_button, 1'b1);
    check1("nop_wb",       wb_en,           1'b0);
    tick();
    check1("nop_pulse_end", continue_button, 1'b0);
    check1("nop_busy_cool", busy,            1'b1);
    ecall = 1'b0;
    tick();
    check1 ("nop_busy_drop", busy, 1'b0);
    check32("nop_pc_adv",    {16'h0, pc}, 32'h0000_0014);

    // PRINT_INT
    a7 = 32'd1; a0 = 32'h1234; ecall = 1'b1;
    tick();
    check32("print_display", display, 32'h0000_1234);
    check32("model_display", m_disp,  32'h0000_1234);
    np = 0;
    repeat (50) begin tick(); if (continue_button) np++; end
    check32("print_no_pulse", np, 0);
    press(10);
    wait_pulse(20, lat);
    check32("print_latency", lat, 7);
    ecall = 1'b0;
    np = 0;
    repeat (10) begin tick(); if (continue_button) np++; end
    check32("print_single_pulse", np, 0);

    // READ_INT
    a7 = 32'd5; switches = 16'hA5A5; ecall = 1'b1;
    repeat (3) tick();
    press(10);
    wait_pulse(20, lat);
    check32("read_latency", lat, 7);
    check32("read_rd_data", rd_data, 32'h0000_A5A5);
    check32("model_rd",     m_rd,    32'h0000_A5A5);
    check1 ("read_wb_en",   wb_en,   1'b1);
    ecall = 1'b0;
    tick();
    check1("read_wb_end", wb_en, 1'b0);
    repeat (3) tick();

    // Bounce during WAIT_PRESS: glitches shorter than D never count
    a7 = 32'd1; a0 = 32'hBEEF; ecall = 1'b1;
    repeat (3) tick();
    np = 0;
    for (int c = 0; c < 40; ) begin
      button_raw = 1'b1;
      repeat ($urandom_range(1, 3)) begin tick(); c++; if (continue_button) np++; end
      button_raw = 1'b0;
      repeat ($urandom_range(1, 3)) begin tick(); c++; if (continue_button) np++; end
    end
    check32("bounce_no_pulse", np, 0);
    check1 ("bounce_busy",     busy, 1'b1);
    press(8);
    wait_pulse(20, lat);
    check32("bounce_then_press", lat, 7);
    ecall = 1'b0;
    repeat (3) tick();

    // Back-to-back ecalls with ecall held high
    pc_load_val = 16'h0020; load_seq++;
    repeat (2) tick();
    a7 = 32'd1; a0 = 32'h1111; ecall = 1'b1;
    repeat (3) tick();
    press(8);
    wait_pulse(20, lat);
    check32("b2b_first", lat, 7);
    a0 = 32'h2222;
    np = 0;
    repeat (30) begin tick(); if (continue_button) np++; end
    check32("b2b_needs_second", np, 0);
    check32("b2b_pc",           {16'h0, pc}, 32'h0000_0024);
    check32("b2b_display",      display, 32'h0000_2222);
    press(8);
    wait_pulse(20, lat);
    check32("b2b_second", lat, 7);
    ecall = 1'b0;
    repeat (3) tick();

    // Randomized service calls; the model checks every cycle
    for (int t = 0; t < 25; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a7 = 32'd0;
        1, 2: a7 = 32'd1;
        3, 4: a7 = 32'd5;
        default: begin a7 = $urandom; if (a7 == 32'd10) a7 = 32'd3; end
      endcase
      a0 = $urandom; switches = 16'($urandom); ecall = 1'b1;
      if (a7 == 32'd1 || a7 == 32'd5) begin
        tick();
        if ($urandom_range(0, 4) == 0) begin
          repeat ($urandom_range(1, 6)) tick();
          ecall = 1'b0;
          repeat (3) tick();
          continue;
        end
        repeat ($urandom_range(0, 3)) begin
          button_raw = 1'b1; repeat ($urandom_range(1, 3)) tick();
          button_raw = 1'b0; repeat ($urandom_range(1, 3)) tick();
        end
        press($urandom_range(6, 12));
      end
      wait_pulse(40, lat);
      check1("rand_pulse_seen", lat > 0, 1'b1);
      ecall = 1'($urandom_range(0, 1));
      repeat (2) tick();
      if (!ecall) repeat ($urandom_range(0, 3)) tick();
    end
    ecall = 1'b0;
    repeat (4) tick();

    // Reset in WAIT_RELEASE abandons the call
    a7 = 32'd5; switches = 16'h5A5A; ecall = 1'b1;
    repeat (3) tick();
    button_raw = 1'b1;
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    check1 ("arst_continue", continue_button, 1'b0);
    check1 ("arst_wb",       wb_en,           1'b0);
    check1 ("arst_busy",     busy,            1'b0);
    check32("arst_display",  display,         32'h0);
    check32("arst_rd_data",  rd_data,         32'h0);
    button_raw = 1'b0; ecall = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    np = 0;
    repeat (15) begin tick(); if (continue_button) np++; end
    check32("arst_no_pulse", np, 0);

    // EXIT
    a7 = 32'd10; ecall = 1'b1;
    tick();
    check1("exit_halted", halted, 1'b1);
    np = 0;
    button_raw = 1'b1; repeat (8) begin tick(); if (continue_button) np++; end
    button_raw = 1'b0; repeat (20) begin tick(); if (continue_button) np++; end
    check32("exit_no_pulse", np, 0);
    check1 ("exit_still_halted", halted, 1'b1);
    #2 reset = 1'b0;
    #1;
    check1("exit_reset_halted", halted, 1'b0);
    check1("exit_reset_busy",   busy,   1'b0);
    ecall = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check1("exit_idle_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
